// File: rtl/rc4_crack_controller.sv
// Top-level sequencer for one RC4 brute-force core: loads the ciphertext once per search,
// then walks candidate keys through S-init, KSA and PRGA/decrypt until a valid key is found.
module rc4_crack_controller #(
    parameter int unsigned             KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0]    KEY_START = 24'h000000,
    parameter logic [KEY_WIDTH-1:0]    KEY_END   = 24'h3FFFFF,
    parameter int unsigned             KEY_STEP  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    output logic                 rom_reset,
    input  logic                 rom_done,
    output logic                 init_start,
    input  logic                 init_done,
    output logic                 ksa_start,
    input  logic                 ksa_done,
    output logic                 prga_start,
    input  logic                 prga_done,
    input  logic                 prga_valid,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 key_found,
    output logic                 key_exhausted,
    output logic [3:0]           phase
);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StMsgRst    = 4'd1,
        StMsgSettle = 4'd2,
        StMsgWait   = 4'd3,
        StInitGo    = 4'd4,
        StInitWait  = 4'd5,
        StKsaGo     = 4'd6,
        StKsaWait   = 4'd7,
        StPrgaGo    = 4'd8,
        StPrgaWait  = 4'd9,
        StNextKey   = 4'd10,
        StFound     = 4'd11,
        StExhausted = 4'd12
    } state_t;

    // One extra bit so the end-of-range test cannot be fooled by wrap-around.
    localparam logic [KEY_WIDTH:0] StepExt = (KEY_WIDTH + 1)'(KEY_STEP);
    localparam logic [KEY_WIDTH:0] EndExt  = {1'b0, KEY_END};

    state_t             state;
    logic [KEY_WIDTH:0] key_next;

    assign key_next = {1'b0, secret_key} + StepExt;
    assign phase    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            secret_key    <= KEY_START;
            rom_reset     <= 1'b0;
            init_start    <= 1'b0;
            ksa_start     <= 1'b0;
            prga_start    <= 1'b0;
            busy          <= 1'b0;
            key_found     <= 1'b0;
            key_exhausted <= 1'b0;
        end else begin
            rom_reset  <= 1'b0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            prga_start <= 1'b0;
            case (state)
                StIdle, StFound, StExhausted: begin
                    // A sibling's stop only blocks a fresh search from IDLE.
                    if (start && !(stop && state == StIdle)) begin
                        state         <= StMsgRst;
                        rom_reset     <= 1'b1;
                        busy          <= 1'b1;
                        secret_key    <= KEY_START;
                        key_found     <= 1'b0;
                        key_exhausted <= 1'b0;
                    end
                end
                StMsgRst:    state <= StMsgSettle;
                // The reader's done flag lags its reset by a cycle, so skip it here.
                StMsgSettle: state <= StMsgWait;
                StMsgWait: begin
                    if (rom_done) begin
                        state      <= StInitGo;
                        init_start <= 1'b1;
                    end
                end
                StInitGo:    state <= StInitWait;
                StInitWait: begin
                    if (init_done) begin
                        state     <= StKsaGo;
                        ksa_start <= 1'b1;
                    end
                end
                StKsaGo:     state <= StKsaWait;
                StKsaWait: begin
                    if (ksa_done) begin
                        state      <= StPrgaGo;
                        prga_start <= 1'b1;
                    end
                end
                StPrgaGo:    state <= StPrgaWait;
                StPrgaWait: begin
                    if (prga_done) begin
                        if (prga_valid) begin
                            state     <= StFound;
                            busy      <= 1'b0;
                            key_found <= 1'b1;
                        end else begin
                            state <= StNextKey;
                        end
                    end
                end
                StNextKey: begin
                    if (stop) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (key_next > EndExt) begin
                        state         <= StExhausted;
                        busy          <= 1'b0;
                        key_exhausted <= 1'b1;
                    end else begin
                        state      <= StInitGo;
                        init_start <= 1'b1;
                        secret_key <= key_next[KEY_WIDTH-1:0];
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_crack_controller.sv
// Bench for rc4_crack_controller: one default-range core and one interleaved small-range core,
// driven by procedural sub-block responders with a key scoreboard.
module tb_rc4_crack_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b, stop, rom_done;
    logic init_done, ksa_done, prga_done, prga_valid;

    logic        rom_reset_a, init_start_a, ksa_start_a, prga_start_a;
    logic        busy_a, key_found_a, key_exhausted_a;
    logic [23:0] secret_key_a;
    logic [3:0]  phase_a;

    logic        rom_reset_b, init_start_b, ksa_start_b, prga_start_b;
    logic        busy_b, key_found_b, key_exhausted_b;
    logic [23:0] secret_key_b;
    logic [3:0]  phase_b;

    rc4_crack_controller dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop),
        .rom_reset(rom_reset_a), .rom_done(rom_done),
        .init_start(init_start_a), .init_done(init_done),
        .ksa_start(ksa_start_a), .ksa_done(ksa_done),
        .prga_start(prga_start_a), .prga_done(prga_done), .prga_valid(prga_valid),
        .secret_key(secret_key_a), .busy(busy_a), .key_found(key_found_a),
        .key_exhausted(key_exhausted_a), .phase(phase_a)
    );

    rc4_crack_controller #(
        .KEY_WIDTH(24), .KEY_START(24'h000010), .KEY_END(24'h000013), .KEY_STEP(2)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop),
        .rom_reset(rom_reset_b), .rom_done(rom_done),
        .init_start(init_start_b), .init_done(init_done),
        .ksa_start(ksa_start_b), .ksa_done(ksa_done),
        .prga_start(prga_start_b), .prga_done(prga_done), .prga_valid(prga_valid),
        .secret_key(secret_key_b), .busy(busy_b), .key_found(key_found_b),
        .key_exhausted(key_exhausted_b), .phase(phase_b)
    );

    int checks = 0;
    int failures = 0;
    int init_cnt_a = 0;
    int init_cnt_b = 0;
    int rr_cnt_a = 0;

    always @(posedge clk) begin
        if (init_start_a) init_cnt_a <= init_cnt_a + 1;
        if (init_start_b) init_cnt_b <= init_cnt_b + 1;
        if (rom_reset_a)  rr_cnt_a   <= rr_cnt_a + 1;
    end

    // Selected-instance view used by the shared tasks.
    bit          sel = 1'b0;
    logic        s_rr, s_init, s_ksa, s_prga, s_busy, s_found, s_exh;
    logic [23:0] s_key;
    logic [3:0]  s_phase;
    assign s_rr    = sel ? rom_reset_b     : rom_reset_a;
    assign s_init  = sel ? init_start_b    : init_start_a;
    assign s_ksa   = sel ? ksa_start_b     : ksa_start_a;
    assign s_prga  = sel ? prga_start_b    : prga_start_a;
    assign s_busy  = sel ? busy_b          : busy_a;
    assign s_found = sel ? key_found_b     : key_found_a;
    assign s_exh   = sel ? key_exhausted_b : key_exhausted_a;
    assign s_key   = sel ? secret_key_b    : secret_key_a;
    assign s_phase = sel ? phase_b         : phase_a;

    logic [23:0] exp_q[$];

    typedef struct {
        bit          sel;
        logic [23:0] key_start;
        int          step;
        int          nkeys;
        bit          found;
        int          rom_delay;
    } vec_t;

    vec_t vecs[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic start_bit(input int idx);
        case (idx)
            0:       return s_init;
            1:       return s_ksa;
            default: return s_prga;
        endcase
    endfunction

    task automatic wait_for(input int idx, input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (start_bit(idx)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: got no pulse required pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic sb_compare();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_key: got %0h required no launch", s_key);
        end else begin
            check("sb_key", 32'(s_key), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic pulse_start();
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Runs one candidate key through the three sub-block models.
    task automatic do_key(input logic valid, input bit stop_mid, output bit ok);
        wait_for(0, 100, "init_start", ok);
        if (!ok) return;
        sb_compare();
        repeat (2) @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
        wait_for(1, 20, "ksa_start", ok);
        if (!ok) return;
        @(negedge clk);
        if (stop_mid) stop = 1'b1;
        @(negedge clk);
        ksa_done = 1'b1;
        @(negedge clk);
        ksa_done = 1'b0;
        wait_for(2, 20, "prga_start", ok);
        if (!ok) return;
        repeat (2) @(negedge clk);
        prga_valid = valid;
        prga_done  = 1'b1;
        @(negedge clk);
        prga_done  = 1'b0;
        prga_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_phase"},   32'(phase_a), 0);
        check({tag, "_busy"},    32'(busy_a), 0);
        check({tag, "_key"},     32'(secret_key_a), 0);
        check({tag, "_found"},   32'(key_found_a), 0);
        check({tag, "_exh"},     32'(key_exhausted_a), 0);
        check({tag, "_starts"},  32'({rom_reset_a, init_start_a, ksa_start_a, prga_start_a}), 0);
        check({tag, "_key_b"},   32'(secret_key_b), 32'h10);
    endtask

    initial begin
        bit ok;
        bit seen;
        int ic0;
        int rr0;

        vecs[0] = '{1'b0, 24'h000000, 1, 3, 1'b1, 70};
        vecs[1] = '{1'b1, 24'h000010, 2, 2, 1'b0, 5};

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; stop = 1'b0; rom_done = 1'b0;
        init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0; prga_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Found path on the default core, exhausted path on the interleaved core.
        for (int v = 0; v < 2; v++) begin
            sel = vecs[v].sel;
            rom_done = 1'b0;
            ic0 = sel ? init_cnt_b : init_cnt_a;
            for (int k = 0; k < vecs[v].nkeys; k++)
                exp_q.push_back(24'(32'(vecs[v].key_start) + k * vecs[v].step));
            pulse_start();
            check("launch_rom_reset", 32'(s_rr), 1);
            check("launch_busy", 32'(s_busy), 1);
            repeat (vecs[v].rom_delay) @(negedge clk);
            rom_done = 1'b1;
            for (int k = 0; k < vecs[v].nkeys; k++) begin
                do_key(k == vecs[v].nkeys - 1 && vecs[v].found, 1'b0, ok);
                if (!ok) break;
            end
            repeat (3) @(negedge clk);
            check("end_found", 32'(s_found), 32'(vecs[v].found));
            check("end_exhausted", 32'(s_exh), 32'(!vecs[v].found));
            check("end_key", 32'(s_key),
                  32'(vecs[v].key_start) + 32'((vecs[v].nkeys - 1) * vecs[v].step));
            check("end_busy", 32'(s_busy), 0);
            check("end_phase", 32'(s_phase), vecs[v].found ? 32'd11 : 32'd12);
            check("init_pulses", 32'((sel ? init_cnt_b : init_cnt_a) - ic0), 32'(vecs[v].nkeys));
            check("sb_drained", 32'(exp_q.size()), 0);
            exp_q.delete();
        end

        // Restart from FOUND, then stop arrives during KSA of key 5.
        sel = 1'b0;
        rr0 = rr_cnt_a;
        for (int k = 0; k <= 5; k++) exp_q.push_back(24'(k));
        pulse_start();
        check("restart_found_clr", 32'(key_found_a), 0);
        check("restart_key", 32'(secret_key_a), 0);
        check("restart_phase", 32'(phase_a), 1);
        @(negedge clk);
        check("restart_rr_once", 32'(rr_cnt_a - rr0), 1);
        for (int k = 0; k <= 5; k++) begin
            do_key(1'b0, k == 5, ok);
            if (!ok) break;
        end
        @(negedge clk);
        check("stop_phase", 32'(phase_a), 0);
        check("stop_busy", 32'(busy_a), 0);
        check("stop_found", 32'(key_found_a), 0);
        check("stop_exh", 32'(key_exhausted_a), 0);
        check("stop_key", 32'(secret_key_a), 5);
        ic0 = init_cnt_a;
        pulse_start();
        repeat (20) @(negedge clk);
        check("stop_blocks_start", 32'(phase_a), 0);
        check("stop_no_key6", 32'(init_cnt_a - ic0), 0);
        check("rr_total", 32'(rr_cnt_a - rr0), 1);
        stop = 1'b0;
        exp_q.delete();

        // Stale rom_done: held high into the search, dropped a cycle after rom_reset.
        exp_q.push_back(24'h0);
        pulse_start();
        check("stale_rom_reset", 32'(rom_reset_a), 1);
        @(negedge clk);
        rom_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (init_start_a) seen = 1'b1;
        end
        check("stale_no_init", 32'(seen), 0);
        check("stale_phase", 32'(phase_a), 3);
        pulse_start();
        check("busy_ignores_start", 32'(phase_a), 3);
        rom_done = 1'b1;
        wait_for(0, 10, "stale_init", ok);
        if (ok) begin
            sb_compare();
            @(negedge clk);
            ksa_done = 1'b1;
            @(negedge clk);
            ksa_done = 1'b0;
            check("spurious_phase", 32'(phase_a), 5);
            check("spurious_ksa_start", 32'(ksa_start_a), 0);
            init_done = 1'b1;
            @(negedge clk);
            init_done = 1'b0;
            check("ksa_after_init", 32'(ksa_start_a), 1);
            @(negedge clk);
            ksa_done = 1'b1;
            @(negedge clk);
            ksa_done = 1'b0;
            check("prga_after_ksa", 32'(prga_start_a), 1);
            @(negedge clk);
            check("prga_wait_phase", 32'(phase_a), 9);
            reset = 1'b1;
            @(negedge clk);
            check_reset_values("midrun");
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
